// File: rtl/fifo_reader_if.sv
// Bus bundle for fifo_reader: FIFO read port plus downstream valid/ready port.
// words_read is present only when FIFO_READER_COUNT_EN is defined.
interface fifo_reader_if #(
    parameter int DATA_WIDTH = 12,
    parameter int CNT_WIDTH  = 16
);
    logic [DATA_WIDTH-1:0] FIFO_data_out;
    logic                  FIFO_empty;
    logic                  FIFO_almost_empty;
    logic                  read_enable;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  valid_out;
    logic                  ready_in;
`ifdef FIFO_READER_COUNT_EN
    logic [CNT_WIDTH-1:0]  words_read;
`else
    if (CNT_WIDTH < 1) begin : g_cnt_width_check
        $error("CNT_WIDTH must be at least 1");
    end
`endif

    // master: the reader itself; slave: the FIFO and downstream consumer
    modport master (
        input  FIFO_data_out, FIFO_empty, FIFO_almost_empty, ready_in,
`ifdef FIFO_READER_COUNT_EN
        output words_read,
`endif
        output read_enable, data_out, valid_out
    );

    modport slave (
        output FIFO_data_out, FIFO_empty, FIFO_almost_empty, ready_in,
`ifdef FIFO_READER_COUNT_EN
        input  words_read,
`endif
        input  read_enable, data_out, valid_out
    );
endinterface

// File: rtl/fifo_reader.sv
// Read-side FIFO controller with a 2-entry skid buffer absorbing the FIFO's read latency.
// Optional delivered-word counter enabled by defining FIFO_READER_COUNT_EN.
module fifo_reader #(
    parameter int DATA_WIDTH = 12,
    parameter int CNT_WIDTH  = 16
) (
    input  logic          clk,
    input  logic          Reset,
    fifo_reader_if.master bus
);
    typedef enum logic [1:0] {IDLE, FILL, FULL} state_e;

    state_e                state_q, state_d;
    logic                  inflight_q, inflight_d;
    logic [1:0]            buf_cnt_q, buf_cnt_d;
    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic [DATA_WIDTH-1:0] tail_q, tail_d;
    logic                  valid, pop, rd_en;
    logic [2:0]            occupancy;

    always_comb begin
        valid     = (buf_cnt_q != 2'd0);
        pop       = valid && bus.ready_in;
        occupancy = {1'b0, buf_cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
        // Flags lag a pop by one cycle, so near empty a read never follows a read.
        rd_en     = !Reset && !bus.FIFO_empty && (occupancy < 3'd2)
                    && !(bus.FIFO_almost_empty && inflight_q);

        inflight_d = rd_en;
        buf_cnt_d  = buf_cnt_q;
        head_d     = head_q;
        tail_d     = tail_q;
        case ({inflight_q, pop})
            2'b01: begin
                head_d    = tail_q;
                buf_cnt_d = buf_cnt_q - 2'd1;
            end
            2'b10: begin
                if (buf_cnt_q == 2'd0) head_d = bus.FIFO_data_out;
                else                   tail_d = bus.FIFO_data_out;
                buf_cnt_d = buf_cnt_q + 2'd1;
            end
            2'b11: begin
                if (buf_cnt_q == 2'd1) begin
                    head_d = bus.FIFO_data_out;
                end else begin
                    head_d = tail_q;
                    tail_d = bus.FIFO_data_out;
                end
            end
            default: ;
        endcase

        state_d = state_q;
        case (state_q)
            IDLE: if (rd_en) state_d = FILL;
            FILL: begin
                if (buf_cnt_d == 2'd2)                        state_d = FULL;
                else if (buf_cnt_d == 2'd0 && !inflight_d)    state_d = IDLE;
            end
            FULL: if (pop) state_d = FILL;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q    <= IDLE;
            inflight_q <= 1'b0;
            buf_cnt_q  <= 2'd0;
            head_q     <= '0;
            tail_q     <= '0;
        end else begin
            state_q    <= state_d;
            inflight_q <= inflight_d;
            buf_cnt_q  <= buf_cnt_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
        end
    end

    assign bus.read_enable = rd_en;
    assign bus.data_out    = head_q;
    assign bus.valid_out   = valid;

`ifdef FIFO_READER_COUNT_EN
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (pop && cnt_q != '1) cnt_d = cnt_q + CNT_WIDTH'(1);
    end

    always_ff @(posedge clk) begin
        if (Reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign bus.words_read = cnt_q;
`else
    if (CNT_WIDTH < 1) begin : g_cnt_width_check
        $error("CNT_WIDTH must be at least 1");
    end
`endif
endmodule

// File: tb/tb_fifo_reader.sv
// Scoreboard bench for fifo_reader: a queue-based FIFO model with lagging flags feeds the DUT,
// accepted writes become expected words, and a negedge monitor checks every delivered word.
module tb_fifo_reader;
    localparam int DW         = 12;
    localparam int CW         = 4;
    localparam int FIFO_DEPTH = 8;

    logic clk = 1'b0;
    logic Reset;
    always #5 clk = ~clk;

    fifo_reader_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();
    fifo_reader #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (.clk(clk), .Reset(Reset), .bus(bus));

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] exp_q[$];
    logic          push_en   = 1'b0;
    logic [DW-1:0] push_data = '0;
    int unsigned   n_reads   = 0;
    int unsigned   n_pops    = 0;
    int unsigned   pops_model = 0;
    bit            done;

    // FIFO model: one-cycle read latency, flags reflect occupancy of the previous cycle
    always @(posedge clk) begin
        int unsigned n_before;
        n_before = fifo_q.size();
        if (Reset) begin
            fifo_q.delete();
            exp_q.delete();
            bus.FIFO_data_out     <= '0;
            bus.FIFO_empty        <= 1'b1;
            bus.FIFO_almost_empty <= 1'b0;
        end else begin
            if (bus.read_enable === 1'b1 && fifo_q.size() != 0)
                bus.FIFO_data_out <= fifo_q.pop_front();
            if (push_en && fifo_q.size() < FIFO_DEPTH) begin
                fifo_q.push_back(push_data);
                exp_q.push_back(push_data);
            end
            bus.FIFO_empty        <= (n_before == 0);
            bus.FIFO_almost_empty <= (n_before >= 1 && n_before <= 2);
        end
    end

    logic          stall_prev = 1'b0;
    logic          re_prev    = 1'b0;
    logic [DW-1:0] held       = '0;

    always @(negedge clk) begin
        logic [DW-1:0] exp;
        int unsigned   exp_cnt;
        if (Reset) begin
            checks++;
            if (bus.read_enable !== 1'b0) begin
                errors++;
                $display("FAIL rst_read_forced: read_enable=%b, required 0", bus.read_enable);
            end
            stall_prev = 1'b0;
            re_prev    = 1'b0;
            pops_model = 0;
        end else begin
`ifdef FIFO_READER_COUNT_EN
            exp_cnt = (pops_model < (1 << CW) - 1) ? pops_model : (1 << CW) - 1;
            checks++;
            if (32'(bus.words_read) !== exp_cnt) begin
                errors++;
                $display("FAIL words_read: got %0d, required %0d", bus.words_read, exp_cnt);
            end
`else
            exp_cnt = 0;
`endif
            if (bus.valid_out === 1'b1 && bus.ready_in === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_extra: got word %h, required no word", bus.data_out);
                end else begin
                    exp = exp_q.pop_front();
                    if (bus.data_out !== exp) begin
                        errors++;
                        $display("FAIL sb_data: got %h, required %h", bus.data_out, exp);
                    end
                end
                pops_model++;
                n_pops++;
            end
            if (stall_prev) begin
                checks++;
                if (bus.valid_out !== 1'b1 || bus.data_out !== held) begin
                    errors++;
                    $display("FAIL stall_hold: got valid=%b data=%h, required valid=1 data=%h",
                             bus.valid_out, bus.data_out, held);
                end
            end
            if (bus.read_enable === 1'b1) begin
                n_reads++;
                checks++;
                if (fifo_q.size() == 0) begin
                    errors++;
                    $display("FAIL underflow: read_enable=1 with %0d words, required >0", fifo_q.size());
                end else if (bus.FIFO_almost_empty === 1'b1 && re_prev) begin
                    errors++;
                    $display("FAIL ae_spacing: reads on consecutive cycles near empty, required gap");
                end
            end
            stall_prev = (bus.valid_out === 1'b1) && (bus.ready_in === 1'b0);
            held       = bus.data_out;
            re_prev    = (bus.read_enable === 1'b1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, got, want);
        end
    endtask

    task automatic push_word(input logic [DW-1:0] d);
        int unsigned guard = 0;
        while (fifo_q.size() >= FIFO_DEPTH && guard < 200) begin
            tick();
            guard++;
        end
        check("push_wait_bounded", 32'(guard < 200), 32'd1);
        push_en   = 1'b1;
        push_data = d;
        tick();
        push_en   = 1'b0;
    endtask

    task automatic drain(input string name, input int unsigned budget);
        int unsigned c = 0;
        while ((exp_q.size() != 0 || fifo_q.size() != 0 || bus.valid_out !== 1'b0) && c < budget) begin
            tick();
            c++;
        end
        checks++;
        if (exp_q.size() != 0 || bus.valid_out !== 1'b0) begin
            errors++;
            $display("FAIL %s_drain: %0d words outstanding valid_out=%b, required 0 and 0",
                     name, exp_q.size(), bus.valid_out);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [DW-1:0] w[8];
        int unsigned   base;

        Reset        = 1'b1;
        bus.ready_in = 1'b1;
        repeat (3) tick();
        check("rst_read_enable", 32'(bus.read_enable), 32'd0);
        check("rst_valid_out",   32'(bus.valid_out),   32'd0);
        check("rst_data_out",    32'(bus.data_out),    32'd0);
`ifdef FIFO_READER_COUNT_EN
        check("rst_words_read",  32'(bus.words_read),  32'd0);
`endif
        Reset = 1'b0;
        tick();

        // five sequential words, consumer always ready
        for (int i = 1; i <= 5; i++) push_word(DW'(i));
        drain("seq5", 60);

        // reset while the FIFO and buffer hold words
        bus.ready_in = 1'b0;
        for (int i = 0; i < 4; i++) push_word(DW'(12'h100 + i));
        repeat (3) tick();
        Reset = 1'b1;
        tick();
        check("midrst_read_enable", 32'(bus.read_enable), 32'd0);
        check("midrst_valid_out",   32'(bus.valid_out),   32'd0);
`ifdef FIFO_READER_COUNT_EN
        check("midrst_words_read",  32'(bus.words_read),  32'd0);
`endif
        Reset = 1'b0;
        bus.ready_in = 1'b1;
        repeat (10) tick();
        check("midrst_no_stale", 32'(bus.valid_out), 32'd0);

        // long stall with a full FIFO
        bus.ready_in = 1'b0;
        n_reads = 0;
        for (int i = 0; i < 8; i++) begin
            w[i] = DW'($urandom);
            push_word(w[i]);
        end
        repeat (10) tick();
        check("stall_reads",     n_reads, 32'd2);
        check("stall_valid",     32'(bus.valid_out), 32'd1);
        check("stall_head",      32'(bus.data_out),  32'(w[0]));
        base = n_pops;
        bus.ready_in = 1'b1;
        drain("stall8", 80);
        check("stall_delivered", n_pops - base, 32'd8);

        // almost-empty region: two words only
        n_reads = 0;
        push_word(DW'(12'hA5A));
        push_word(DW'(12'h5A5));
        drain("ae2", 40);
        check("ae_reads", n_reads, 32'd2);

        // ready toggling every cycle, FIFO kept refilled
        base = n_pops;
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 100; i++) push_word(DW'($urandom));
                done = 1'b1;
            end
            begin
                while (!done) begin
                    bus.ready_in = ~bus.ready_in;
                    tick();
                end
            end
        join
        bus.ready_in = 1'b1;
        drain("toggle100", 300);
        check("toggle_delivered", n_pops - base, 32'd100);
`ifdef FIFO_READER_COUNT_EN
        check("words_read_sat", 32'(bus.words_read), 32'd15);
`endif

        // random consumer stalls and bursty producer
        base = n_pops;
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 150; i++) begin
                    push_word(DW'($urandom));
                    repeat ($urandom_range(0, 2)) tick();
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    bus.ready_in = ($urandom_range(0, 3) != 0);
                    tick();
                end
            end
        join
        bus.ready_in = 1'b1;
        drain("random150", 300);
        check("random_delivered", n_pops - base, 32'd150);

        Reset = 1'b1;
        repeat (2) tick();
        check("final_valid_out", 32'(bus.valid_out), 32'd0);
`ifdef FIFO_READER_COUNT_EN
        check("final_words_read", 32'(bus.words_read), 32'd0);
`endif
        Reset = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
